// File: rtl/inclusive_cache_flush_initiator.sv
// Range-flush TL-UL initiator for the InclusiveCache control port: one PutFullData per
// cache line to the Flush64 register, with AccessAcks tracked by source slot.
module inclusive_cache_flush_initiator #(
  parameter logic [25:0] CTRL_BASE       = 26'h2010000,
  parameter logic [25:0] FLUSH64_OFFSET  = 26'h200,
  parameter int          LINE_BYTES      = 64,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [32:0] cmd_base,
  input  logic [15:0] cmd_lines,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [2:0]  a_opcode,
  output logic [2:0]  a_param,
  output logic [1:0]  a_size,
  output logic [10:0] a_source,
  output logic [25:0] a_address,
  output logic [7:0]  a_mask,
  output logic [63:0] a_data,
  output logic        a_corrupt,
  output logic        d_ready,
  input  logic        d_valid,
  input  logic [2:0]  d_opcode,
  input  logic [1:0]  d_size,
  input  logic [10:0] d_source,
  input  logic [63:0] d_data
);

  localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                     state_reg, state_next;
  logic [32:0]                addr_reg, addr_next;
  logic [15:0]                remaining_reg, remaining_next;
  logic [MAX_OUTSTANDING-1:0] inuse_reg, inuse_next;
  logic                       a_valid_reg, a_valid_next;
  logic [SLOT_W-1:0]          a_source_reg, a_source_next;
  logic [32:0]                a_data_reg, a_data_next;
  logic                       done_reg, done_next;
  logic                       error_reg, error_next;

  logic                       a_fire;
  logic                       d_src_ok;
  logic [SLOT_W-1:0]          d_slot;
  logic                       d_active;
  logic                       d_bad;
  logic [MAX_OUTSTANDING-1:0] d_onehot, fire_onehot;
  logic [MAX_OUTSTANDING-1:0] clr_mask, set_mask, inuse_after, taken;
  logic                       free_found;
  logic [SLOT_W-1:0]          free_slot;
  logic [15:0]                rem_after;
  logic                       unused_d;

  assign a_fire   = a_valid_reg && a_ready;
  assign d_src_ok = (d_source < 11'(MAX_OUTSTANDING));
  assign d_slot   = d_source[SLOT_W-1:0];
  assign d_active = d_valid && (state_reg != IDLE);
  assign unused_d = ^{d_size, d_data};

  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot
    assign d_onehot[gi]    = d_src_ok && (d_slot == SLOT_W'(gi));
    assign fire_onehot[gi] = (a_source_reg == SLOT_W'(gi));
  end

  // Responses to free or out-of-range slots flag an error but leave the bitmap alone.
  assign clr_mask    = d_active ? (d_onehot & inuse_reg) : '0;
  assign set_mask    = a_fire ? fire_onehot : '0;
  assign inuse_after = (inuse_reg & ~clr_mask) | set_mask;
  assign d_bad       = d_active && ((d_opcode != 3'h0) || !d_src_ok ||
                                    ((d_onehot & inuse_reg) == '0));

  // A slot freed this cycle only becomes eligible for the next assertion.
  assign taken = inuse_reg | set_mask;

  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!taken[i]) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(i);
      end
    end
  end

  assign rem_after = remaining_reg - (a_fire ? 16'd1 : 16'd0);

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    inuse_next     = inuse_after;
    a_valid_next   = a_valid_reg;
    a_source_next  = a_source_reg;
    a_data_next    = a_data_reg;
    done_next      = 1'b0;
    error_next     = error_reg | d_bad;

    case (state_reg)
      IDLE: begin
        a_valid_next = 1'b0;
        if (cmd_valid) begin
          error_next = 1'b0;
          if (cmd_lines == 16'd0) begin
            done_next = 1'b1;
          end else begin
            addr_next      = cmd_base & ~33'(LINE_BYTES - 1);
            remaining_next = cmd_lines;
            state_next     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (a_fire) begin
          addr_next      = addr_reg + 33'(LINE_BYTES);
          remaining_next = rem_after;
        end
        if (a_fire || !a_valid_reg) begin
          a_valid_next = (rem_after != 16'd0) && free_found;
          if (a_valid_next) begin
            a_source_next = free_slot;
            a_data_next   = addr_next;
          end
        end
        if (a_fire && (rem_after == 16'd0)) begin
          a_valid_next = 1'b0;
          if (inuse_after == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        a_valid_next = 1'b0;
        if (inuse_after == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        a_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      inuse_reg     <= '0;
      a_valid_reg   <= 1'b0;
      a_source_reg  <= '0;
      a_data_reg    <= '0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      inuse_reg     <= inuse_next;
      a_valid_reg   <= a_valid_next;
      a_source_reg  <= a_source_next;
      a_data_reg    <= a_data_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign error     = error_reg;

  assign a_valid   = a_valid_reg;
  assign a_opcode  = 3'h0;
  assign a_param   = 3'h0;
  assign a_size    = 2'h3;
  assign a_source  = 11'(a_source_reg);
  assign a_address = CTRL_BASE + FLUSH64_OFFSET;
  assign a_mask    = 8'hFF;
  assign a_data    = {31'h0, a_data_reg};
  assign a_corrupt = 1'b0;
  assign d_ready   = 1'b1;

endmodule

// File: tb/tb_inclusive_cache_flush_initiator.sv
// Randomised bench for inclusive_cache_flush_initiator with a transaction-level model of
// line addresses, outstanding slots, error and completion.
module tb_inclusive_cache_flush_initiator;

  localparam int MAXO = 4;
  localparam int LINE = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [32:0] cmd_base = '0;
  logic [15:0] cmd_lines = '0;
  logic        busy, done, error;
  logic        a_valid;
  logic        a_ready = 1'b0;
  logic [2:0]  a_opcode, a_param;
  logic [1:0]  a_size;
  logic [10:0] a_source;
  logic [25:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        d_ready;
  logic        d_valid = 1'b0;
  logic [2:0]  d_opcode = '0;
  logic [1:0]  d_size = 2'h3;
  logic [10:0] d_source = '0;
  logic [63:0] d_data = '0;

  always #5 clock = ~clock;

  inclusive_cache_flush_initiator dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_lines(cmd_lines),
    .busy(busy), .done(done), .error(error),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt),
    .d_ready(d_ready), .d_valid(d_valid), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_data(d_data)
  );

  typedef struct {
    int         slot;
    int         due;
    logic [2:0] op;
  } ack_t;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  ack_t        ackq[$];
  bit [MAXO-1:0] out_model = '0;
  bit          active_m = 0, err_m = 0, done_exp = 0;
  int          issued = 0, lines_req = 0;
  logic [32:0] next_addr = '0;
  bit          prev_stall = 0;
  logic [10:0] prev_src = '0;
  logic [63:0] prev_data = '0;

  // stimulus controls
  int          cyc = 0;
  bit          checks_on = 0, rst_req = 1;
  bit          cmd_pending = 0;
  logic [32:0] pend_base = '0;
  logic [15:0] pend_lines = '0;
  int          ready_pct = 100, ack_min = 1, ack_max = 1, stall_left = 0;
  logic [2:0]  next_ack_op = 3'h0;
  bit          inj_valid = 0;
  logic [2:0]  inj_op = '0;
  logic [10:0] inj_src = '0;

  // directed observations
  int          accept_cyc = 0, last_done_cyc = -1, max_seen = 0;
  logic        done_err = 1'b0;
  logic [63:0] last_fire_data = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle();
    int   pick;
    ack_t e;
    @(negedge clock);
    cyc++;
    if (checks_on) begin
      check_val("done", done, done_exp);
      check_val("busy", busy, active_m);
      check_val("cmd_ready", cmd_ready, !active_m);
      check_val("error", error, err_m);
      check_val("d_ready", d_ready, 1);
      if (!active_m) check_val("a_valid_idle", a_valid, 0);
      if ($countones(out_model) == MAXO) check_val("a_valid_full", a_valid, 0);
      if (prev_stall) begin
        check_val("stall_valid", a_valid, 1);
        check_val("stall_source", a_source, prev_src);
        check_val("stall_data", a_data, prev_data);
        check_val("stall_address", a_address, 26'h2010200);
      end
      if (done) begin
        last_done_cyc = cyc;
        done_err = error;
      end
    end
    done_exp = 1'b0;

    if (rst_req) begin
      reset = 1'b1; cmd_valid = 1'b0; a_ready = 1'b0; d_valid = 1'b0;
      active_m = 0; err_m = 0; out_model = '0; prev_stall = 0;
      rst_req = 0; checks_on = 1;
      return;
    end
    reset = 1'b0;

    // D channel: injected response first, otherwise any ack that has come due
    d_valid = 1'b0; d_opcode = 3'h0; d_source = '0;
    if (inj_valid) begin
      d_valid = 1'b1; d_opcode = inj_op; d_source = inj_src; inj_valid = 0;
    end else begin
      pick = -1;
      foreach (ackq[i]) if (pick < 0 && ackq[i].due <= cyc) pick = i;
      if (pick >= 0) begin
        d_valid = 1'b1; d_opcode = ackq[pick].op; d_source = 11'(ackq[pick].slot);
        ackq.delete(pick);
      end
    end
    if (d_valid && active_m) begin
      if (d_opcode != 3'h0 || d_source >= MAXO || !out_model[d_source[1:0]]) err_m = 1;
      if (d_source < MAXO && out_model[d_source[1:0]]) out_model[d_source[1:0]] = 1'b0;
    end

    // A channel
    if (stall_left > 0 && a_valid) begin
      a_ready = 1'b0;
      stall_left--;
    end else begin
      a_ready = ($urandom_range(0, 99) < ready_pct);
    end
    if (checks_on && a_valid && a_ready && active_m) begin
      check_val("extra_put", issued < lines_req, 1);
      check_val("a_source_range", a_source < MAXO, 1);
      if (a_source < MAXO) check_val("a_source_free", out_model[a_source[1:0]], 0);
      if (issued == 0) check_val("a_source_first", a_source, 0);
      check_val("a_data", a_data, {31'h0, next_addr});
      check_val("a_address", a_address, 26'h2010200);
      check_val("a_mask", a_mask, 8'hFF);
      check_val("a_size", a_size, 2'h3);
      check_val("a_opcode", a_opcode, 3'h0);
      check_val("a_param", a_param, 3'h0);
      check_val("a_corrupt", a_corrupt, 1'b0);
      $display("put %0d/%0d source=%0d data=%h", issued + 1, lines_req, a_source, a_data);
      out_model[a_source[1:0]] = 1'b1;
      issued++;
      next_addr = next_addr + 33'(LINE);
      last_fire_data = a_data;
      e.slot = int'(a_source[1:0]);
      e.due = cyc + int'($urandom_range(ack_min, ack_max));
      e.op = next_ack_op;
      next_ack_op = 3'h0;
      ackq.push_back(e);
      if ($countones(out_model) > max_seen) max_seen = $countones(out_model);
    end
    prev_stall = active_m && a_valid && !a_ready;
    prev_src = a_source;
    prev_data = a_data;

    if (active_m && issued == lines_req && out_model == '0) begin
      active_m = 0;
      done_exp = 1'b1;
    end

    cmd_valid = 1'b0;
    if (cmd_pending && !active_m && !done_exp) begin
      cmd_valid = 1'b1; cmd_base = pend_base; cmd_lines = pend_lines;
      cmd_pending = 0; accept_cyc = cyc;
      err_m = 0; issued = 0; lines_req = int'(pend_lines);
      next_addr = pend_base & ~33'(LINE - 1);
      $display("cmd base=%h lines=%0d", pend_base, pend_lines);
      if (pend_lines == 16'd0) done_exp = 1'b1;
      else active_m = 1;
    end
  endtask

  task automatic start_cmd(input logic [32:0] base, input logic [15:0] lines);
    pend_base = base;
    pend_lines = lines;
    cmd_pending = 1;
    last_done_cyc = -1;
    max_seen = 0;
  endtask

  task automatic run_until_idle();
    int n = 0;
    while ((cmd_pending || active_m || ackq.size() > 0) && n < 3000) begin
      cycle();
      n++;
    end
    if (n >= 3000) check_val("timeout", 1, 0);
    cycle();
    cycle();
  endtask

  initial begin
    int n;
    cycle();
    rst_req = 1;
    cycle();
    cycle();

    // single line, one-cycle ack
    ack_min = 1; ack_max = 1; ready_pct = 100;
    start_cmd(33'h0_8000_0047, 16'd1);
    run_until_idle();
    check_val("t1_latency", last_done_cyc - accept_cyc, 4);
    check_val("t1_data", last_fire_data, 64'h80000040);
    check_val("t1_error", done_err, 0);

    // ten lines, slow acks: window fills
    ack_min = 20; ack_max = 20;
    start_cmd(33'h0_8000_0000, 16'd10);
    run_until_idle();
    check_val("t2_max_outstanding", max_seen, MAXO);
    check_val("t2_last_data", last_fire_data, 64'h80000240);
    check_val("t2_done_seen", last_done_cyc > accept_cyc, 1);

    // five-cycle stall on A
    ack_min = 2; ack_max = 2; stall_left = 5;
    start_cmd(33'h0_1234_5678, 16'd1);
    run_until_idle();
    check_val("t3_stall_used", stall_left, 0);
    check_val("t3_puts", issued, 1);

    // address wrap
    ack_min = 1; ack_max = 3;
    start_cmd(33'h1_FFFF_FFC0, 16'd2);
    run_until_idle();
    check_val("t4_wrap_data", last_fire_data, 64'h0);
    check_val("t4_error", done_err, 0);

    // AccessAckData plus a response on an unused source
    ack_min = 8; ack_max = 8; next_ack_op = 3'h1;
    start_cmd(33'h0_0000_1000, 16'd2);
    for (int i = 0; i < 4; i++) cycle();
    inj_op = 3'h0; inj_src = 11'd3; inj_valid = 1;
    run_until_idle();
    check_val("t5_error_at_done", done_err, 1);
    start_cmd(33'h0_0000_2000, 16'd0);
    run_until_idle();
    check_val("t5_zero_latency", last_done_cyc - accept_cyc, 1);
    check_val("t5_zero_puts", issued, 0);

    // reset with two Puts outstanding
    ack_min = 30; ack_max = 30; ready_pct = 100;
    start_cmd(33'h0_4000_0000, 16'd4);
    n = 0;
    while ($countones(out_model) < 2 && n < 50) begin
      cycle();
      n++;
    end
    check_val("t6_outstanding", $countones(out_model), 2);
    last_done_cyc = -1;
    rst_req = 1;
    cycle();
    run_until_idle();
    check_val("t6_no_done", last_done_cyc, -1);

    // random commands
    for (int k = 0; k < 10; k++) begin
      ready_pct = int'($urandom_range(30, 100));
      ack_min = 1;
      ack_max = int'($urandom_range(1, 12));
      stall_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      start_cmd({1'($urandom_range(0, 1)), 32'($urandom())}, 16'($urandom_range(1, 20)));
      run_until_idle();
      check_val("rand_puts", issued, lines_req);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inclusive_cache_flush_initiator.md
Name: inclusive_cache_flush_initiator

Overview:
- TL-UL initiator that drives the L2 cache control port, i.e. the ctrls ctrl_in slave interface.
- Accepts range-flush commands (base address plus line count) from a core-side or debug agent.
- Issues one PutFullData per cache line to the 64-bit flush register, tracks up to MAX_OUTSTANDING AccessAcks, and reports completion and errors.
- Sits between a management/debug master and the InclusiveCache ctrl_in port.

Parameters:
- CTRL_BASE, 26'h2010000, base address of the L2 control register block.
- FLUSH64_OFFSET, 26'h200, offset of the 64-bit flush register.
- LINE_BYTES, 64, cache line size in bytes; power of two.
- MAX_OUTSTANDING, 4, in-flight Puts and source-ID slots; power of two, 1..8.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  flush command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_base  in  33  first address to flush; low log2(LINE_BYTES) bits ignored
- cmd_lines  in  16  number of lines to flush
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky error flag, cleared on next command accept
- a_valid  out  1  TL A valid
- a_ready  in  1  TL A ready
- a_opcode  out  3  always 3'h0 (PutFullData)
- a_param  out  3  always 0
- a_size  out  2  always 2'h3
- a_source  out  11  slot index, zero-extended
- a_address  out  26  CTRL_BASE+FLUSH64_OFFSET
- a_mask  out  8  always 8'hFF
- a_data  out  64  {31'h0, line address[32:0]}
- a_corrupt  out  1  always 0
- d_ready  out  1  always 1
- d_valid  in  1  TL D valid
- d_opcode  in  3  response opcode
- d_size  in  2  response size
- d_source  in  11  response source
- d_data  in  64  ignored

Behaviour:
- Reset (synchronous):
  - State goes to IDLE.
  - a_valid, busy, done and error all read 0 in the cycle after reset is sampled.
  - Slot bitmap, counters and address register are cleared.
  - Reset mid-operation abandons the command; no done pulse.
- States:
  - IDLE: cmd_ready=1, busy=0.
  - ISSUE: busy=1.
  - DRAIN: busy=1.
  - cmd_ready=0 in ISSUE and DRAIN.
- Command accept (IDLE, cmd_valid&cmd_ready):
  - error is cleared.
  - cmd_lines==0: done pulses the next cycle and the block stays IDLE.
  - Otherwise latch addr = cmd_base with the low log2(LINE_BYTES) bits zeroed, set remaining=cmd_lines, go to ISSUE.
- ISSUE:
  - a_valid is a register. It is asserted when remaining>0 and a free slot exists.
  - On assertion, a_source = lowest free slot and a_data = current addr; both are captured at that point.
  - All a_* fields hold stable while a_valid&!a_ready.
  - On A fire: mark the slot in use, addr += LINE_BYTES (mod 2^33, wrap silently), remaining -= 1.
  - a_valid may re-assert the cycle after a fire (back-to-back) if a slot is free.
  - When remaining reaches 0 after a fire, go to DRAIN.
- D response (d_valid; d_ready always 1):
  - Clears the in-use bit of d_source[log2(MAX_OUTSTANDING)-1:0].
  - Sets error if any of these holds:
    - d_opcode != 3'h0 (not AccessAck);
    - d_source >= MAX_OUTSTANDING;
    - the addressed slot is not in use.
  - A spurious response does not change the bitmap.
  - Responses in IDLE are consumed and ignored; error is unchanged.
- Simultaneous A fire and D response in one cycle: both take effect. A slot freed this cycle is eligible for the next a_valid assertion, not the current one.
- DRAIN: once the bitmap is all zero, go to IDLE with done=1 for exactly one cycle. Transition ISSUE->IDLE directly if the bitmap is already empty on the last fire plus its response in the same cycle.
- error persists through done until the next command accept. It does not abort issuing.
- Full condition: all slots in use means a_valid stays 0 until a response arrives.
- Minimum latency: single line with a_ready=1 and one-cycle response gives done 4 cycles after cmd accept.

Test Plan:
- Single line, cmd_base=33'h0_8000_0047, cmd_lines=1, a_ready=1, AccessAck one cycle later -> one Put with a_data=64'h80000040, address 26'h2010200, mask FF, size 3; done one pulse; error=0.
- 10 lines from 33'h0_8000_0000, a_ready=1, D acks delayed 20 cycles -> exactly 4 Puts outstanding, a_valid low while full; a_data steps by 0x40 to 0x80000240; done after the 10th ack.
- a_ready held 0 for 5 cycles with a_valid high -> source, data and address unchanged across the stall; one fire only.
- cmd_base=33'h1_FFFF_FFC0, cmd_lines=2 -> second a_data=64'h0 (wrap); done; error=0.
- AccessAckData (3'h1) response, then a D with unused source 3 -> error=1 through done; error cleared on next cmd accept; cmd_lines=0 -> done pulse the next cycle, no A traffic.
- Reset asserted with 2 Puts outstanding -> a_valid=0, busy=0, done never pulses; late acks in IDLE are ignored with error=0.
